axi4_stream_downsizer: RTL and testbench



---
 rtl/axi4_stream_downsizer.sv | 184 ++++++++++++++++++
 tb/tb_axi4_stream_downsizer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_stream_downsizer.sv
// Purpose : splits each S_TDATA_W-bit AXI4-Stream beat into RATIO narrow M_TDATA_W-bit beats,
//           lane 0 first, optionally skipping trailing lanes whose tkeep slice is all zero.
// Latency : a wide beat accepted at edge N shows lane 0 on m_* from edge N+1; one narrow beat per cycle.
// Backpr. : s_tready is high in IDLE, or on the final-lane handshake (m_tready & last lane) so the
//           next wide beat loads without a bubble; m_* are held steady while m_tready is low.
//
// Ports:
//   clk, rst_n                         - clock, asynchronous active-low reset
//   s_tvalid/s_tready                  - wide-side handshake
//   s_tdata/s_tstrb/s_tkeep            - wide beat payload and byte qualifiers
//   s_tlast/s_tid/s_tdest/s_tuser      - wide-side sideband
//   m_tvalid/m_tready                  - narrow-side handshake
//   m_tdata/m_tstrb/m_tkeep            - current narrow lane
//   m_tlast/m_tid/m_tdest/m_tuser      - narrow-side sideband (copied from the held wide beat)
module axi4_stream_downsizer #(
  parameter int S_TDATA_W = 64,
  parameter int M_TDATA_W = 16,
  parameter int TID_W     = 1,
  parameter int TDEST_W   = 1,
  parameter int TUSER_W   = 1,
  parameter int TRIM_NULL = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // wide slave side
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic [S_TDATA_W-1:0]   s_tdata,
  input  logic [S_TDATA_W/8-1:0] s_tstrb,
  input  logic [S_TDATA_W/8-1:0] s_tkeep,
  input  logic                   s_tlast,
  input  logic [TID_W-1:0]       s_tid,
  input  logic [TDEST_W-1:0]     s_tdest,
  input  logic [TUSER_W-1:0]     s_tuser,
  // narrow master side
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [M_TDATA_W-1:0]   m_tdata,
  output logic [M_TDATA_W/8-1:0] m_tstrb,
  output logic [M_TDATA_W/8-1:0] m_tkeep,
  output logic                   m_tlast,
  output logic [TID_W-1:0]       m_tid,
  output logic [TDEST_W-1:0]     m_tdest,
  output logic [TUSER_W-1:0]     m_tuser
);

  localparam int RATIO    = S_TDATA_W / M_TDATA_W;
  localparam int LANE_W   = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int S_KEEP_W = S_TDATA_W / 8;
  localparam int M_KEEP_W = M_TDATA_W / 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [LANE_W-1:0]     lane_q, lane_d;
  logic [LANE_W-1:0]     last_q, last_d;
  logic [S_TDATA_W-1:0]  data_q, data_d;
  logic [S_KEEP_W-1:0]   strb_q, strb_d;
  logic [S_KEEP_W-1:0]   keep_q, keep_d;
  logic                  tlast_q, tlast_d;
  logic [TID_W-1:0]      tid_q, tid_d;
  logic [TDEST_W-1:0]    tdest_q, tdest_d;
  logic [TUSER_W-1:0]    tuser_q, tuser_d;

  logic [LANE_W-1:0]     in_last_lane;
  logic                  at_last;
  logic                  load;

  // Index of the final lane to emit for the incoming wide beat. With trimming,
  // the scan keeps overwriting so the highest non-null lane wins; an all-null
  // beat still yields lane 0 so exactly one (null) beat carries tlast.
  always_comb begin
    in_last_lane = '0;
    if (TRIM_NULL != 0) begin
      for (int k = 0; k < RATIO; k++) begin
        if (|s_tkeep[k*M_KEEP_W +: M_KEEP_W]) begin
          in_last_lane = LANE_W'(k);
        end
      end
    end else begin
      in_last_lane = LANE_W'(RATIO - 1);
    end
  end

  assign at_last = (lane_q == last_q);

  // Next-state and handshake logic. The only combinational input->output path
  // is m_tready -> s_tready on the last lane; m_tvalid depends on state alone.
  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    last_d   = last_q;
    data_d   = data_q;
    strb_d   = strb_q;
    keep_d   = keep_q;
    tlast_d  = tlast_q;
    tid_d    = tid_q;
    tdest_d  = tdest_q;
    tuser_d  = tuser_q;
    s_tready = 1'b0;
    m_tvalid = 1'b0;
    load     = 1'b0;

    unique case (state_q)
      IDLE: begin
        s_tready = 1'b1;
        load     = s_tvalid;
      end
      SEND: begin
        m_tvalid = 1'b1;
        if (m_tready) begin
          if (!at_last) begin
            lane_d = lane_q + LANE_W'(1);
          end else begin
            // Final lane drains this cycle: free the holding register and,
            // if a new wide beat is offered, take it without a bubble.
            s_tready = 1'b1;
            if (s_tvalid) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load) begin
      state_d = SEND;
      lane_d  = '0;
      last_d  = in_last_lane;
      data_d  = s_tdata;
      strb_d  = s_tstrb;
      keep_d  = s_tkeep;
      tlast_d = s_tlast;
      tid_d   = s_tid;
      tdest_d = s_tdest;
      tuser_d = s_tuser;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lane_q  <= '0;
      last_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      keep_q  <= '0;
      tlast_q <= 1'b0;
      tid_q   <= '0;
      tdest_q <= '0;
      tuser_q <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      last_q  <= last_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      keep_q  <= keep_d;
      tlast_q <= tlast_d;
      tid_q   <= tid_d;
      tdest_q <= tdest_d;
      tuser_q <= tuser_d;
    end
  end

  // Outputs come straight from the holding register, so they cannot change
  // while stalled: lane_q only advances on an accepted narrow beat.
  assign m_tdata = data_q[int'(lane_q)*M_TDATA_W +: M_TDATA_W];
  assign m_tstrb = strb_q[int'(lane_q)*M_KEEP_W +: M_KEEP_W];
  assign m_tkeep = keep_q[int'(lane_q)*M_KEEP_W +: M_KEEP_W];
  assign m_tlast = (state_q == SEND) && at_last && tlast_q;
  assign m_tid   = tid_q;
  assign m_tdest = tdest_q;
  assign m_tuser = tuser_q;

endmodule

// File: tb/tb_axi4_stream_downsizer.sv
// Purpose : directed plus randomized check of the 64->16 downsizer against a lane-list model.
// Latency : checks lane 0 one cycle after acceptance and back-to-back narrow beats.
// Backpr. : randomized m_tready with stability checks on every stalled cycle.
module tb_axi4_stream_downsizer;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // instance under main test: TRIM_NULL = 1, 4-bit sidebands
  logic        s_tvalid, s_tready, s_tlast;
  logic [63:0] s_tdata;
  logic [7:0]  s_tstrb, s_tkeep;
  logic [3:0]  s_tid, s_tdest, s_tuser;
  logic        m_tvalid, m_tready, m_tlast;
  logic [15:0] m_tdata;
  logic [1:0]  m_tstrb, m_tkeep;
  logic [3:0]  m_tid, m_tdest, m_tuser;

  // second instance: TRIM_NULL = 0, default sidebands
  logic        s1_tvalid, s1_tready, s1_tlast;
  logic [63:0] s1_tdata;
  logic [7:0]  s1_tstrb, s1_tkeep;
  logic [0:0]  s1_tid, s1_tdest, s1_tuser;
  logic        m1_tvalid, m1_tready, m1_tlast;
  logic [15:0] m1_tdata;
  logic [1:0]  m1_tstrb, m1_tkeep;
  logic [0:0]  m1_tid, m1_tdest, m1_tuser;

  axi4_stream_downsizer #(
    .S_TDATA_W(64), .M_TDATA_W(16), .TID_W(4), .TDEST_W(4), .TUSER_W(4), .TRIM_NULL(1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tstrb(s_tstrb),
    .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tstrb(m_tstrb),
    .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tid(m_tid), .m_tdest(m_tdest), .m_tuser(m_tuser)
  );

  axi4_stream_downsizer #(
    .S_TDATA_W(64), .M_TDATA_W(16), .TID_W(1), .TDEST_W(1), .TUSER_W(1), .TRIM_NULL(0)
  ) u_dut_notrim (
    .clk(clk), .rst_n(rst_n),
    .s_tvalid(s1_tvalid), .s_tready(s1_tready), .s_tdata(s1_tdata), .s_tstrb(s1_tstrb),
    .s_tkeep(s1_tkeep), .s_tlast(s1_tlast), .s_tid(s1_tid), .s_tdest(s1_tdest), .s_tuser(s1_tuser),
    .m_tvalid(m1_tvalid), .m_tready(m1_tready), .m_tdata(m1_tdata), .m_tstrb(m1_tstrb),
    .m_tkeep(m1_tkeep), .m_tlast(m1_tlast), .m_tid(m1_tid), .m_tdest(m1_tdest), .m_tuser(m1_tuser)
  );

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  strb;
    logic [1:0]  keep;
    logic        last;
    logic [3:0]  id;
    logic [3:0]  dest;
    logic [3:0]  user;
    logic        srdy;   // s_tready seen on this handshake: high only on the final lane
  } nb_t;

  nb_t         exp_q[$];
  nb_t         got_q[$];
  int          got_cyc[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  bit          acc = 1'b0;
  bit          stall_prev = 1'b0;
  logic [33:0] prev_m = '0;

  function automatic logic [33:0] cur_m();
    return {m_tvalid, m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: the wide beat becomes a list of lanes 0..L, where L is the lane
  // holding the highest set tkeep bit (0 if none).
  task automatic model_push();
    int  ll;
    nb_t e;
    ll = 0;
    for (int b = 7; b >= 0; b--) begin
      if (s_tkeep[b]) begin
        ll = b / 2;
        break;
      end
    end
    for (int k = 0; k <= ll; k++) begin
      e.d    = s_tdata[16*k +: 16];
      e.strb = s_tstrb[2*k +: 2];
      e.keep = s_tkeep[2*k +: 2];
      e.last = (k == ll) && s_tlast;
      e.id   = s_tid;
      e.dest = s_tdest;
      e.user = s_tuser;
      e.srdy = (k == ll);
      exp_q.push_back(e);
    end
  endtask

  // One cycle: sample at the falling edge (values that the next rising edge
  // will act on), then return 1 time unit after the rising edge.
  task automatic tick();
    nb_t g;
    @(negedge clk);
    acc = 1'b0;
    if (rst_n) begin
      if (stall_prev) chk("stall_stable", cur_m(), prev_m);
      if (s_tvalid && s_tready) begin
        model_push();
        acc     = 1'b1;
        acc_cyc = cyc;
      end
      if (m_tvalid && m_tready) begin
        g.d    = m_tdata;
        g.strb = m_tstrb;
        g.keep = m_tkeep;
        g.last = m_tlast;
        g.id   = m_tid;
        g.dest = m_tdest;
        g.user = m_tuser;
        g.srdy = s_tready;
        got_q.push_back(g);
        got_cyc.push_back(cyc);
      end
      stall_prev = m_tvalid && !m_tready;
      prev_m     = cur_m();
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic [63:0] d, input logic [7:0] strb, input logic [7:0] keep,
                       input logic last, input logic [3:0] id, input logic [3:0] dest,
                       input logic [3:0] user);
    s_tdata  = d;
    s_tstrb  = strb;
    s_tkeep  = keep;
    s_tlast  = last;
    s_tid    = id;
    s_tdest  = dest;
    s_tuser  = user;
    s_tvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (acc) break;
    end
    if (!acc) chk("accept_timeout", acc, 1);
  endtask

  task automatic wait_out();
    for (int i = 0; i < 300 && got_q.size() < exp_q.size(); i++) tick();
    repeat (3) tick();
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) chk(tag, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
    got_cyc.delete();
  endtask

  initial begin
    logic [23:0] exp1 [4];
    logic [63:0] w;
    int          n1;
    int          sent;

    s_tvalid = 0; s_tdata = '0; s_tstrb = '0; s_tkeep = '0; s_tlast = 0;
    s_tid = '0; s_tdest = '0; s_tuser = '0; m_tready = 0;
    s1_tvalid = 0; s1_tdata = '0; s1_tstrb = '0; s1_tkeep = '0; s1_tlast = 0;
    s1_tid = '0; s1_tdest = '0; s1_tuser = '0; m1_tready = 0;

    // reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_s_tready", s_tready, 1);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_notrim_s_tready", s1_tready, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // basic 64->16 split, latency and tlast placement
    m_tready = 1;
    drive(64'h4444_3333_2222_1111, 8'hFF, 8'hFF, 1'b1, 4'h5, 4'hA, 4'h3);
    s_tvalid = 0;
    wait_out();
    chk("basic_first_latency", got_cyc.size() > 0 ? got_cyc[0] : -1, acc_cyc + 1);
    chk("basic_span", got_cyc.size() >= 4 ? got_cyc[3] - got_cyc[0] : -1, 3);
    chk("basic_lane0", got_q.size() >= 4 ? got_q[0].d : '0, 16'h1111);
    chk("basic_lane3", got_q.size() >= 4 ? got_q[3].d : '0, 16'h4444);
    chk("basic_last_lane2", got_q.size() >= 4 ? got_q[2].last : 1'b1, 0);
    chk("basic_last_lane3", got_q.size() >= 4 ? got_q[3].last : 1'b0, 1);
    compare_all("basic");

    // trailing null lanes trimmed
    drive(64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, 8'h0F, 1'b1, 4'h1, 4'h2, 4'h4);
    s_tvalid = 0;
    wait_out();
    chk("trim_beats", got_q.size(), 2);
    chk("trim_keep1", got_q.size() >= 2 ? got_q[1].keep : 2'b00, 2'b11);
    chk("trim_last1", got_q.size() >= 2 ? got_q[1].last : 1'b0, 1);
    compare_all("trim");

    // all-null wide beat still yields one beat carrying tlast
    drive(64'h0123_4567_89AB_CDEF, 8'h00, 8'h00, 1'b1, 4'h7, 4'h8, 4'h9);
    s_tvalid = 0;
    wait_out();
    chk("null_beats", got_q.size(), 1);
    chk("null_keep", got_q.size() >= 1 ? got_q[0].keep : 2'b11, 0);
    chk("null_last", got_q.size() >= 1 ? got_q[0].last : 1'b0, 1);
    compare_all("null");

    // TRIM_NULL = 0 instance always emits four beats
    w = 64'h4444_3333_2222_1111;
    for (int k = 0; k < 4; k++) begin
      exp1[k] = {w[16*k +: 16], 2'(8'h0F >> (2*k)), 2'(8'h0F >> (2*k)), (k == 3), 3'b111};
    end
    s1_tdata = w; s1_tstrb = 8'h0F; s1_tkeep = 8'h0F; s1_tlast = 1;
    s1_tid = 1; s1_tdest = 1; s1_tuser = 1; m1_tready = 1; s1_tvalid = 1;
    @(posedge clk);
    #1 s1_tvalid = 0;
    n1 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (m1_tvalid) begin
        if (n1 < 4) chk("notrim_beat", {m1_tdata, m1_tstrb, m1_tkeep, m1_tlast, m1_tid, m1_tdest, m1_tuser}, exp1[n1]);
        n1++;
      end
    end
    chk("notrim_beats", n1, 4);
    @(posedge clk);
    #1;

    // three wide beats back to back: twelve narrow beats with no gap
    for (int b = 0; b < 3; b++) begin
      drive({$urandom, $urandom}, 8'hFF, 8'hFF, (b == 2), 4'($urandom), 4'($urandom), 4'($urandom));
    end
    s_tvalid = 0;
    wait_out();
    chk("b2b_beats", got_q.size(), 12);
    chk("b2b_span", got_cyc.size() >= 12 ? got_cyc[11] - got_cyc[0] : -1, 11);
    compare_all("b2b");

    // randomized source gaps and 50% m_tready backpressure
    sent = 0;
    for (int i = 0; i < 4000 && (sent < 40 || s_tvalid); i++) begin
      m_tready = 1'($urandom_range(0, 1));
      if (!s_tvalid && sent < 40 && $urandom_range(0, 3) != 0) begin
        s_tdata  = {$urandom, $urandom};
        s_tstrb  = 8'($urandom);
        s_tkeep  = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
        s_tlast  = 1'($urandom);
        s_tid    = 4'($urandom);
        s_tdest  = 4'($urandom);
        s_tuser  = 4'($urandom);
        s_tvalid = 1;
        sent++;
      end
      tick();
      if (acc) s_tvalid = 0;
    end
    m_tready = 1;
    wait_out();
    compare_all("rand");

    // reset in the middle of a packet, after lane 1 has gone out
    drive(64'hDDDD_CCCC_BBBB_AAAA, 8'hFF, 8'hFF, 1'b1, 4'h6, 4'h6, 4'h6);
    s_tvalid = 0;
    for (int i = 0; i < 20 && got_q.size() < 2; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_m_tvalid", m_tvalid, 0);
    chk("midrst_s_tready", s_tready, 1);
    stall_prev = 0;
    chk("midrst_sent", got_q.size(), 2);
    while (got_q.size() > 0 && exp_q.size() > 0) chk("midrst_pre", got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
    got_cyc.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("postrst_s_tready", s_tready, 1);
    chk("postrst_m_tvalid", m_tvalid, 0);
    drive(64'h8888_7777_6666_5555, 8'hFF, 8'hFF, 1'b1, 4'h2, 4'h3, 4'h4);
    s_tvalid = 0;
    wait_out();
    chk("postrst_lane0", got_q.size() > 0 ? got_q[0].d : '0, 16'h5555);
    compare_all("postrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
